// File: rtl/sd_spi_master.sv
// SPI mode-0 byte host for the SD-card link: SCK generation, chip select, MISO sampling.
// Optional post-reset card wake-up clocks are compiled in with `SD_SPI_INIT_CLOCKS_EN.
module sd_spi_master #(
    parameter int DIV_W = 8
`ifdef SD_SPI_INIT_CLOCKS_EN
    , parameter int INIT_CLKS = 80
`endif
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cs_req,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             sd_sck,
    output logic             sd_cs,
    output logic             sd_sdi,
    input  logic             sd_sdo
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_HI = 3'd1,
        SHIFT_LO = 3'd2,
        DONE     = 3'd3
`ifdef SD_SPI_INIT_CLOCKS_EN
        , INIT   = 3'd4
`endif
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

`ifdef SD_SPI_INIT_CLOCKS_EN
    localparam int INIT_W = (INIT_CLKS > 1) ? $clog2(INIT_CLKS) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CLKS - 1);
    localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
`endif

    state_t           state_q, state_d;
    logic [DIV_W-1:0] half_cnt_q, half_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       tx_sr_q, tx_sr_d;
    logic [6:0]       rx_sr_q, rx_sr_d;
    logic             sd_sck_q, sd_sck_d;
    logic             sd_cs_q, sd_cs_d;
    logic             sd_sdi_q, sd_sdi_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        sd_sck_d   = sd_sck_q;
        sd_cs_d    = sd_cs_q;
        sd_sdi_d   = sd_sdi_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
`ifdef SD_SPI_INIT_CLOCKS_EN
        init_cnt_d = init_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                sd_cs_d = ~cs_req;
                // Bit 7 goes out at accept so the first low phase doubles as MOSI setup.
                if (tx_valid && tx_ready_q) begin
                    state_d    = SHIFT_LO;
                    div_d      = clk_div;
                    half_cnt_d = clk_div;
                    tx_sr_d    = tx_data[6:0];
                    sd_sdi_d   = tx_data[7];
                    bit_cnt_d  = 3'd7;
                end
            end
            SHIFT_LO: begin
                if (half_cnt_q == '0) begin
                    state_d    = SHIFT_HI;
                    half_cnt_d = div_q;
                    sd_sck_d   = 1'b1;
                end else begin
                    half_cnt_d = half_cnt_q - DIV_ONE;
                end
            end
            SHIFT_HI: begin
                if (half_cnt_q == '0) begin
                    rx_sr_d    = {rx_sr_q[5:0], sd_sdo};
                    sd_sck_d   = 1'b0;
                    half_cnt_d = div_q;
                    if (bit_cnt_q == 3'd0) begin
                        state_d    = DONE;
                        rx_valid_d = 1'b1;
                        rx_data_d  = {rx_sr_q, sd_sdo};
                        sd_sdi_d   = 1'b1;
                    end else begin
                        state_d   = SHIFT_LO;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        sd_sdi_d  = tx_sr_q[6];
                        tx_sr_d   = {tx_sr_q[5:0], 1'b0};
                    end
                end else begin
                    half_cnt_d = half_cnt_q - DIV_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
`ifdef SD_SPI_INIT_CLOCKS_EN
            INIT: begin
                sd_cs_d  = 1'b1;
                sd_sdi_d = 1'b1;
                if (half_cnt_q == '0) begin
                    half_cnt_d = div_q;
                    if (sd_sck_q) begin
                        sd_sck_d = 1'b0;
                        if (init_cnt_q == INIT_LAST) begin
                            state_d = IDLE;
                        end else begin
                            init_cnt_d = init_cnt_q + INIT_ONE;
                        end
                    end else begin
                        sd_sck_d = 1'b1;
                    end
                end else begin
                    half_cnt_d = half_cnt_q - DIV_ONE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
`ifdef SD_SPI_INIT_CLOCKS_EN
            state_q    <= INIT;
            half_cnt_q <= clk_div;
            div_q      <= clk_div;
            init_cnt_q <= '0;
`else
            state_q    <= IDLE;
            half_cnt_q <= '0;
            div_q      <= '0;
`endif
            bit_cnt_q  <= 3'd0;
            tx_sr_q    <= 7'd0;
            rx_sr_q    <= 7'd0;
            sd_sck_q   <= 1'b0;
            sd_cs_q    <= 1'b1;
            sd_sdi_q   <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            div_q      <= div_d;
`ifdef SD_SPI_INIT_CLOCKS_EN
            init_cnt_q <= init_cnt_d;
`endif
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            sd_sck_q   <= sd_sck_d;
            sd_cs_q    <= sd_cs_d;
            sd_sdi_q   <= sd_sdi_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign sd_sck   = sd_sck_q;
    assign sd_cs    = sd_cs_q;
    assign sd_sdi   = sd_sdi_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master: loopback, constant MISO, back-to-back bytes,
// reset abort, post-reset clocks and a small SD-card SPI responder answering CMD0.
module tb_sd_spi_master;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] clk_div;
    logic       cs_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sd_sck;
    logic       sd_cs;
    logic       sd_sdi;
    logic       sd_sdo;

    int checks = 0;
    int errors = 0;

    // 0 = MISO looped to MOSI, 1 = MISO tied high, 2 = card responder
    logic [1:0]  sdo_mode = 2'd0;
    logic [7:0]  card_tx = 8'hFF;
    logic [7:0]  card_rx = 8'h00;
    logic [7:0]  card_next = 8'hFF;
    logic [47:0] card_hist = 48'h0;
    logic        card_load = 1'b0;
    int          card_bits = 0;
    int          card_pending = 0;

    always #5 clk_sys = ~clk_sys;

    assign sd_sdo = (sdo_mode == 2'd0) ? sd_sdi :
                    (sdo_mode == 2'd1) ? 1'b1 : card_tx[7];

    sd_spi_master dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .clk_div  (clk_div),
        .cs_req   (cs_req),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .sd_sck   (sd_sck),
        .sd_cs    (sd_cs),
        .sd_sdi   (sd_sdi),
        .sd_sdo   (sd_sdo)
    );

    // Card samples MOSI on rising SCK; R1 = 8'h01 comes on the second byte after CMD0.
    always @(posedge sd_sck) begin
        if (!sd_cs) begin
            card_rx = {card_rx[6:0], sd_sdi};
            card_bits++;
            if (card_bits == 8) begin
                card_bits = 0;
                card_hist = {card_hist[39:0], card_rx};
                if (card_hist == 48'h4000_0000_0095) card_pending = 2;
                card_next = (card_pending == 1) ? 8'h01 : 8'hFF;
                if (card_pending > 0) card_pending--;
                card_load = 1'b1;
            end
        end
    end

    always @(negedge sd_sck) begin
        if (!sd_cs) begin
            if (card_load) begin
                card_tx   = card_next;
                card_load = 1'b0;
            end else begin
                card_tx = {card_tx[6:0], 1'b1};
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One byte: accept, then watch SCK/MOSI until rx_valid or the cycle budget expires.
    task automatic applyStimulus(input logic [7:0] b, input logic [7:0] div,
                                 output logic [7:0] rx, output int lat,
                                 output int first_rise, output int period,
                                 output int rises, output int hi_total,
                                 output logic [7:0] mosi);
        int   t;
        logic prev;
        rx = 8'h00; lat = -1; first_rise = -1; period = -1;
        rises = 0; hi_total = 0; mosi = 8'h00;
        for (int k = 0; k < 1000 && !tx_ready; k++) tick();
        tx_data  = b;
        clk_div  = div;
        tx_valid = 1'b1;
        prev     = sd_sck;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h3C;
        clk_div  = 8'hFF;
        t = 1;
        for (int k = 0; k < 2000; k++) begin
            if (sd_sck && !prev) begin
                rises++;
                mosi = {mosi[6:0], sd_sdi};
                if (rises == 1) first_rise = t;
                else if (rises == 2) period = t - first_rise;
            end
            if (sd_sck) hi_total++;
            if (rx_valid) begin
                lat = t;
                rx  = rx_data;
                break;
            end
            prev = sd_sck;
            tick();
            t++;
        end
    endtask

    task automatic releaseReset();
        int   rises;
        logic prev;
        logic cs_high;
        rises   = 0;
        cs_high = 1'b1;
        reset   = 1'b0;
`ifdef SD_SPI_INIT_CLOCKS_EN
        prev = sd_sck;
        for (int k = 0; k < 4000 && !tx_ready; k++) begin
            tick();
            if (sd_sck && !prev) rises++;
            if (!sd_cs) cs_high = 1'b0;
            prev = sd_sck;
        end
        checkOutput("init_rises", rises, 80);
        checkOutput("init_cs_high", cs_high, 1);
        checkOutput("init_then_ready", tx_ready, 1);
`else
        tick();
        checkOutput("ready_after_reset", tx_ready, 1);
        checkOutput("idle_not_busy", busy, 0);
        prev = sd_sck;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (sd_sck && !prev) rises++;
            prev = sd_sck;
        end
        checkOutput("no_sck_after_reset", rises, 0);
        checkOutput("no_sck_cs", cs_high, 1);
`endif
    endtask

    initial begin
        logic [7:0] rx, mosi;
        int lat, first_rise, period, rises, hi_total;
        int n_acc, n_rx, t, rise_gap, found;
        int rx_t[3];
        logic [7:0] rx_b[3];
        logic [7:0] seq[3];
        logic prev;
        logic cs_at_done;

        reset = 1'b1; clk_div = 8'd1; cs_req = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        repeat (3) tick();
        checkOutput("rst_sck", sd_sck, 0);
        checkOutput("rst_cs", sd_cs, 1);
        checkOutput("rst_sdi", sd_sdi, 1);
        checkOutput("rst_rx_data", rx_data, 8'h00);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_tx_ready", tx_ready, 0);
        checkOutput("rst_busy", busy, 0);
        releaseReset();

        // Loopback at clk_div=3
        cs_req = 1'b1;
        tick();
        checkOutput("cs_follows_req", sd_cs, 0);
        sdo_mode = 2'd0;
        applyStimulus(8'hA5, 8'd3, rx, lat, first_rise, period, rises, hi_total, mosi);
        checkOutput("t1_latency", lat, 65);
        checkOutput("t1_rx", rx, 8'hA5);
        checkOutput("t1_mosi", mosi, 8'hA5);
        checkOutput("t1_first_rise", first_rise, 5);
        checkOutput("t1_period", period, 8);
        checkOutput("t1_rises", rises, 8);

        // clk_div=0, MISO high, MOSI all zeros
        sdo_mode = 2'd1;
        applyStimulus(8'h00, 8'd0, rx, lat, first_rise, period, rises, hi_total, mosi);
        checkOutput("t2_latency", lat, 17);
        checkOutput("t2_rx", rx, 8'hFF);
        checkOutput("t2_mosi", mosi, 8'h00);
        checkOutput("t2_first_rise", first_rise, 2);
        checkOutput("t2_period", period, 2);
        checkOutput("t2_hi_cycles", hi_total, 8);
        repeat (3) tick();
        checkOutput("t2_rx_held", rx_data, 8'hFF);
        checkOutput("t2_rx_valid_low", rx_valid, 0);

        // Back-to-back bytes with tx_valid held; cs_req drops during the last byte
        sdo_mode = 2'd0;
        seq[0] = 8'h40; seq[1] = 8'h00; seq[2] = 8'h95;
        for (int i = 0; i < 3; i++) begin rx_t[i] = -1; rx_b[i] = 8'h00; end
        for (int k = 0; k < 100 && !tx_ready; k++) tick();
        clk_div = 8'd1; tx_data = seq[0]; tx_valid = 1'b1;
        n_acc = 0; n_rx = 0; t = 0; rise_gap = -1; cs_at_done = 1'b1;
        prev = sd_sck;
        for (int k = 0; k < 300 && n_rx < 3; k++) begin
            logic acc;
            acc = tx_ready && tx_valid;
            tick();
            t++;
            if (acc) begin
                n_acc++;
                if (n_acc < 3) tx_data = seq[n_acc];
                else begin tx_valid = 1'b0; cs_req = 1'b0; end
            end
            if (sd_sck && !prev && n_rx == 1 && rise_gap < 0) rise_gap = t - rx_t[0];
            if (rx_valid) begin
                rx_t[n_rx] = t;
                rx_b[n_rx] = rx_data;
                cs_at_done = sd_cs;
                n_rx++;
            end
            prev = sd_sck;
        end
        checkOutput("t3_pulses", n_rx, 3);
        checkOutput("t3_first_rx_t", rx_t[0], 33);
        checkOutput("t3_gap01", rx_t[1] - rx_t[0], 34);
        checkOutput("t3_gap12", rx_t[2] - rx_t[1], 34);
        checkOutput("t3_rise_after_done", rise_gap, 4);
        checkOutput("t3_rx0", rx_b[0], 8'h40);
        checkOutput("t3_rx1", rx_b[1], 8'h00);
        checkOutput("t3_rx2", rx_b[2], 8'h95);
        checkOutput("t3_cs_at_done", cs_at_done, 0);
        tick();
        checkOutput("t3_cs_in_idle", sd_cs, 0);
        tick();
        checkOutput("t3_cs_after_idle", sd_cs, 1);

        // Reset during bit 4 aborts the byte
        cs_req = 1'b1;
        for (int k = 0; k < 100 && !tx_ready; k++) tick();
        tx_data = 8'hC3; clk_div = 8'd1; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        rises = 0; prev = sd_sck;
        for (int k = 0; k < 100 && rises < 4; k++) begin
            tick();
            if (sd_sck && !prev) rises++;
            prev = sd_sck;
        end
        checkOutput("t4_reached_bit4", rises, 4);
        reset = 1'b1;
        tick();
        checkOutput("t4_sck", sd_sck, 0);
        checkOutput("t4_cs", sd_cs, 1);
        checkOutput("t4_sdi", sd_sdi, 1);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_rx_data", rx_data, 8'h00);
        found = 0;
        if (rx_valid) found++;
        releaseReset();
        for (int k = 0; k < 80; k++) begin
            if (rx_valid) found++;
            tick();
        end
        checkOutput("t4_no_rx_valid", found, 0);

        // CMD0 to the card responder, then poll for R1
        card_bits = 0; card_tx = 8'hFF; card_load = 1'b0; card_pending = 0; card_hist = 48'h0;
        sdo_mode = 2'd2;
        cs_req = 1'b1;
        tick();
        seq[0] = 8'h40;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] cmd;
            cmd = (i == 0) ? 8'h40 : (i == 5) ? 8'h95 : 8'h00;
            applyStimulus(cmd, 8'd0, rx, lat, first_rise, period, rises, hi_total, mosi);
            checkOutput("t6_cmd_rx_ff", rx, 8'hFF);
        end
        found = 0;
        rx = 8'hFF;
        for (int p = 1; p <= 8 && found == 0; p++) begin
            applyStimulus(8'hFF, 8'd0, rx, lat, first_rise, period, rises, hi_total, mosi);
            if (rx != 8'hFF) found = p;
        end
        checkOutput("t6_r1", rx, 8'h01);
        checkOutput("t6_r1_poll", found, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
